// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg : shared CPU opcodes, field widths and the hazard scoreboard entry
// Rev 1.0
// ============================================================================
package cpu_pkg;

    localparam int REG_W = 5;
    localparam int OP_W  = 5;

    localparam logic [OP_W-1:0] ALU_OP  = 5'b00000;
    localparam logic [OP_W-1:0] BNE_OP  = 5'b00010;
    localparam logic [OP_W-1:0] BLT_OP  = 5'b00011;
    localparam logic [OP_W-1:0] ADDI_OP = 5'b00101;
    localparam logic [OP_W-1:0] LW_OP   = 5'b01000;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] dst;
        logic             ld;
    } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/branch_hazard_unit_if.sv
`default_nettype none
// ============================================================================
// branch_hazard_unit_if : decode-side request and hazard/bypass response bus
// Rev 1.0
// ============================================================================
interface branch_hazard_unit_if #(
    parameter int REG_W = 5,
    parameter int OP_W  = 5,
    parameter int SEL_W = 2
);
    logic             id_valid;
    logic             id_is_branch;
    logic [OP_W-1:0]  id_opcode;
    logic [REG_W-1:0] id_wr_reg;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rd;
    logic             flush;

    logic             stall;
    logic [SEL_W-1:0] fwd_rs_sel;
    logic [SEL_W-1:0] fwd_rd_sel;
    logic             haz_rs;
    logic             haz_rd;
    logic [7:0]       stall_count;

    modport master (
        output id_valid, id_is_branch, id_opcode, id_wr_reg, id_rs, id_rd, flush,
        input  stall, fwd_rs_sel, fwd_rd_sel, haz_rs, haz_rd, stall_count
    );

    modport slave (
        input  id_valid, id_is_branch, id_opcode, id_wr_reg, id_rs, id_rd, flush,
        output stall, fwd_rs_sel, fwd_rd_sel, haz_rs, haz_rd, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/hazard_match.sv
`default_nettype none
// ============================================================================
// hazard_match : youngest in-flight writer lookup for one branch operand
// Rev 1.0
// ============================================================================
module hazard_match #(
    parameter int REG_W = 5,
    parameter int DEPTH = 3,
    parameter int SEL_W = 2
) (
    input  wire logic [REG_W-1:0]       op_i,
    input  wire logic [DEPTH-1:0]       v_i,
    input  wire logic [DEPTH-1:0]       ld_i,
    input  wire logic [DEPTH*REG_W-1:0] dst_i,
    output logic                        hit_o,
    output logic [SEL_W-1:0]            idx_o,
    output logic                        ld_o
);

    // Scan oldest to youngest so the last hit (smallest stage) wins.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        ld_o  = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (v_i[k] && (dst_i[k*REG_W +: REG_W] == op_i) && (op_i != '0)) begin
                hit_o = 1'b1;
                idx_o = SEL_W'(k + 1);
                ld_o  = ld_i[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_hazard_unit.sv
`default_nettype none
// ============================================================================
// branch_hazard_unit : branch-operand bypass/stall control with stall counter
// Rev 1.0
// ============================================================================
module branch_hazard_unit
    import cpu_pkg::*;
#(
    parameter int              REG_W    = cpu_pkg::REG_W,
    parameter int              OP_W     = cpu_pkg::OP_W,
    parameter int              DEPTH    = 3,
    parameter int              LOAD_LAT = 1,
    parameter logic [OP_W-1:0] ALU_OP   = cpu_pkg::ALU_OP,
    parameter logic [OP_W-1:0] ADDI_OP  = cpu_pkg::ADDI_OP,
    parameter logic [OP_W-1:0] LW_OP    = cpu_pkg::LW_OP,
    parameter int              SEL_W    = $clog2(DEPTH + 1)
) (
    input wire logic            clock,
    input wire logic            reset_n,
    branch_hazard_unit_if.slave bus
);

    localparam logic [SEL_W-1:0] c_LOAD_LAT = SEL_W'(LOAD_LAT);

    logic [DEPTH-1:0]       v_q, v_d;
    logic [DEPTH-1:0]       ld_q, ld_d;
    logic [DEPTH*REG_W-1:0] dst_q, dst_d;
    logic [7:0]             stall_count_q, stall_count_d;

    logic             w_is_writer, w_eval, w_stall;
    logic             w_rs_hit, w_rs_ld, w_rs_blk;
    logic             w_rd_hit, w_rd_ld, w_rd_blk;
    logic [SEL_W-1:0] w_rs_idx, w_rd_idx;

    hazard_match #(.REG_W(REG_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_rs (
        .op_i  (bus.id_rs),
        .v_i   (v_q),
        .ld_i  (ld_q),
        .dst_i (dst_q),
        .hit_o (w_rs_hit),
        .idx_o (w_rs_idx),
        .ld_o  (w_rs_ld)
    );

    hazard_match #(.REG_W(REG_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_rd (
        .op_i  (bus.id_rd),
        .v_i   (v_q),
        .ld_i  (ld_q),
        .dst_i (dst_q),
        .hit_o (w_rd_hit),
        .idx_o (w_rd_idx),
        .ld_o  (w_rd_ld)
    );

    assign w_is_writer = bus.id_valid && (bus.id_wr_reg != '0) &&
                         ((bus.id_opcode == ALU_OP) || (bus.id_opcode == ADDI_OP) ||
                          (bus.id_opcode == LW_OP));
    assign w_eval      = bus.id_valid && bus.id_is_branch;

    // A load still inside the load-use window has no bypass path yet.
    assign w_rs_blk = w_eval && w_rs_hit && w_rs_ld && (w_rs_idx <= c_LOAD_LAT);
    assign w_rd_blk = w_eval && w_rd_hit && w_rd_ld && (w_rd_idx <= c_LOAD_LAT);
    assign w_stall  = (w_rs_blk || w_rd_blk) && !bus.flush;

    assign bus.stall       = w_stall;
    assign bus.haz_rs      = w_eval && w_rs_hit;
    assign bus.haz_rd      = w_eval && w_rd_hit;
    assign bus.fwd_rs_sel  = (w_eval && w_rs_hit && !w_rs_blk) ? w_rs_idx : '0;
    assign bus.fwd_rd_sel  = (w_eval && w_rd_hit && !w_rd_blk) ? w_rd_idx : '0;
    assign bus.stall_count = stall_count_q;

    always_comb begin
        v_d   = {v_q[DEPTH-2:0], w_is_writer && !w_stall && !bus.flush};
        ld_d  = {ld_q[DEPTH-2:0], bus.id_opcode == LW_OP};
        dst_d = {dst_q[(DEPTH-1)*REG_W-1:0], bus.id_wr_reg};
        stall_count_d = stall_count_q;
        if (w_stall && (stall_count_q != 8'hFF)) begin
            stall_count_d = stall_count_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v_q           <= '0;
            ld_q          <= '0;
            dst_q         <= '0;
            stall_count_q <= '0;
        end else begin
            v_q           <= v_d;
            ld_q          <= ld_d;
            dst_q         <= dst_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_hazard_unit.sv
`default_nettype none
// ============================================================================
// tb_branch_hazard_unit : LOAD_LAT=1 and LOAD_LAT=2 instances against a model
// Rev 1.0
// ============================================================================
module tb_branch_hazard_unit;
    import cpu_pkg::*;

    typedef struct packed {
        logic       stall;
        logic [1:0] fs;
        logic [1:0] fd;
        logic       hs;
        logic       hd;
    } exp_t;

    typedef struct {
        logic       v, br;
        logic [4:0] opc, wr, rs, rd;
        logic       fl;
        logic       st;
        logic [1:0] fs, fd;
        logic       hs, hd;
        int         cnt;
    } vec_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic       t_valid = 0, t_br = 0, t_flush = 0;
    logic [4:0] t_opc = 0, t_wr = 0, t_rs = 0, t_rd = 0;

    int checks = 0;
    int failures = 0;
    sb_entry_t hq0[$];
    sb_entry_t hq1[$];
    int cnt0 = 0, cnt1 = 0;
    vec_t vq[$];

    always #5 clock = ~clock;

    branch_hazard_unit_if #(.REG_W(5), .OP_W(5), .SEL_W(2)) bus1 ();
    branch_hazard_unit_if #(.REG_W(5), .OP_W(5), .SEL_W(2)) bus2 ();

    assign bus1.id_valid = t_valid;  assign bus2.id_valid = t_valid;
    assign bus1.id_is_branch = t_br; assign bus2.id_is_branch = t_br;
    assign bus1.id_opcode = t_opc;   assign bus2.id_opcode = t_opc;
    assign bus1.id_wr_reg = t_wr;    assign bus2.id_wr_reg = t_wr;
    assign bus1.id_rs = t_rs;        assign bus2.id_rs = t_rs;
    assign bus1.id_rd = t_rd;        assign bus2.id_rd = t_rd;
    assign bus1.flush = t_flush;     assign bus2.flush = t_flush;

    branch_hazard_unit #(.DEPTH(3), .LOAD_LAT(1)) dut1 (.clock(clock), .reset_n(reset_n), .bus(bus1));
    branch_hazard_unit #(.DEPTH(3), .LOAD_LAT(2)) dut2 (.clock(clock), .reset_n(reset_n), .bus(bus2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Youngest writer of r: position in the history, 1 = most recently issued.
    function automatic int youngest(input sb_entry_t q[$], input logic [4:0] r);
        if (r == 0) return 0;
        foreach (q[i]) if (q[i].v && q[i].dst == r) return i + 1;
        return 0;
    endfunction

    function automatic exp_t eval(input sb_entry_t q[$], input int lat);
        exp_t e;
        int ks, kd;
        bit bs, bd;
        e = '0;
        if (!(t_valid && t_br)) return e;
        ks = youngest(q, t_rs);
        kd = youngest(q, t_rd);
        bs = (ks != 0) && q[ks-1].ld && (ks <= lat);
        bd = (kd != 0) && q[kd-1].ld && (kd <= lat);
        e.hs = (ks != 0);
        e.hd = (kd != 0);
        e.fs = bs ? 2'd0 : 2'(ks);
        e.fd = bd ? 2'd0 : 2'(kd);
        e.stall = (bs || bd) && !t_flush;
        return e;
    endfunction

    task automatic advance();
        exp_t e0, e1;
        sb_entry_t n, z;
        z = '0;
        e0 = eval(hq0, 1);
        e1 = eval(hq1, 2);
        n.v = t_valid && (t_wr != 0) && (t_opc == ALU_OP || t_opc == ADDI_OP || t_opc == LW_OP);
        n.dst = t_wr;
        n.ld = (t_opc == LW_OP);
        if (!n.v) n = z;
        hq0.push_front((e0.stall || t_flush) ? z : n);
        hq1.push_front((e1.stall || t_flush) ? z : n);
        if (hq0.size() > 3) void'(hq0.pop_back());
        if (hq1.size() > 3) void'(hq1.pop_back());
        if (e0.stall) cnt0 = (cnt0 < 255) ? cnt0 + 1 : 255;
        if (e1.stall) cnt1 = (cnt1 < 255) ? cnt1 + 1 : 255;
    endtask

    task automatic model_check();
        exp_t e;
        e = eval(hq0, 1);
        chk("L1 stall", bus1.stall, e.stall);
        chk("L1 fwd_rs", bus1.fwd_rs_sel, e.fs);
        chk("L1 fwd_rd", bus1.fwd_rd_sel, e.fd);
        chk("L1 haz_rs", bus1.haz_rs, e.hs);
        chk("L1 haz_rd", bus1.haz_rd, e.hd);
        chk("L1 count", bus1.stall_count, cnt0);
        e = eval(hq1, 2);
        chk("L2 stall", bus2.stall, e.stall);
        chk("L2 fwd_rs", bus2.fwd_rs_sel, e.fs);
        chk("L2 fwd_rd", bus2.fwd_rd_sel, e.fd);
        chk("L2 haz_rs", bus2.haz_rs, e.hs);
        chk("L2 haz_rd", bus2.haz_rd, e.hd);
        chk("L2 count", bus2.stall_count, cnt1);
    endtask

    task automatic at_neg();
        @(negedge clock);
        model_check();
    endtask

    task automatic step_edge();
        advance();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int v, br, opc, wr, rs, rd, fl);
        t_valid = 1'(v); t_br = 1'(br); t_opc = 5'(opc);
        t_wr = 5'(wr); t_rs = 5'(rs); t_rd = 5'(rd); t_flush = 1'(fl);
    endtask

    task automatic add_vec(input int v, br, opc, wr, rs, rd, fl, st, fs, fd, hs, hd, cnt);
        vec_t x;
        x.v = 1'(v); x.br = 1'(br); x.opc = 5'(opc); x.wr = 5'(wr);
        x.rs = 5'(rs); x.rd = 5'(rd); x.fl = 1'(fl); x.st = 1'(st);
        x.fs = 2'(fs); x.fd = 2'(fd); x.hs = 1'(hs); x.hd = 1'(hd); x.cnt = cnt;
        vq.push_back(x);
    endtask

    initial begin
        int n1, n2, fd1, fd2, ok;
        bit d1, d2;

        add_vec(1, 1, BNE_OP,  0, 3, 3, 0,  0, 0, 0, 0, 0, 0);
        add_vec(1, 0, ADDI_OP, 5, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        add_vec(1, 1, BNE_OP,  0, 5, 6, 0,  0, 1, 0, 1, 0, 0);
        add_vec(1, 1, BNE_OP,  0, 5, 6, 0,  0, 2, 0, 1, 0, 0);
        add_vec(1, 1, BNE_OP,  0, 5, 6, 0,  0, 3, 0, 1, 0, 0);
        add_vec(1, 1, BNE_OP,  0, 5, 6, 0,  0, 0, 0, 0, 0, 0);
        add_vec(1, 0, LW_OP,   7, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        add_vec(1, 1, BLT_OP,  0, 1, 7, 0,  1, 0, 0, 0, 1, 0);
        add_vec(1, 1, BLT_OP,  0, 1, 7, 0,  0, 0, 2, 0, 1, 1);
        add_vec(1, 0, ALU_OP,  4, 1, 2, 0,  0, 0, 0, 0, 0, 1);
        add_vec(1, 0, ADDI_OP, 4, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        add_vec(1, 1, BNE_OP,  0, 4, 4, 0,  0, 1, 1, 1, 1, 1);
        add_vec(0, 1, BNE_OP,  0, 4, 4, 0,  0, 0, 0, 0, 0, 1);
        add_vec(1, 0, ADDI_OP, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        add_vec(1, 1, BLT_OP,  0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        add_vec(0, 0, ALU_OP,  0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        add_vec(1, 0, LW_OP,   2, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        add_vec(1, 1, BLT_OP,  0, 2, 2, 1,  0, 0, 0, 1, 1, 1);
        add_vec(1, 1, BLT_OP,  0, 2, 2, 0,  0, 2, 2, 1, 1, 1);
        add_vec(1, 0, ADDI_OP, 9, 0, 0, 1,  0, 0, 0, 0, 0, 1);
        add_vec(1, 1, BNE_OP,  0, 9, 9, 0,  0, 0, 0, 0, 0, 1);

        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Randomized traffic over a small register set to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            t_valid = ($urandom_range(0, 9) != 0);
            t_br    = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 4))
                0: t_opc = ALU_OP;
                1: t_opc = ADDI_OP;
                2, 3: t_opc = LW_OP;
                default: t_opc = 5'($urandom);
            endcase
            if (t_br) t_opc = ($urandom_range(0, 1) != 0) ? BNE_OP : BLT_OP;
            t_wr    = 5'($urandom_range(0, 3));
            t_rs    = 5'($urandom_range(0, 3));
            t_rd    = 5'($urandom_range(0, 3));
            t_flush = ($urandom_range(0, 9) == 0);
            at_neg();
            step_edge();
        end

        // Asynchronous reset in the middle of a load-use stall.
        drive(0, 0, ALU_OP, 0, 0, 0, 0);
        repeat (3) begin at_neg(); step_edge(); end
        drive(1, 0, LW_OP, 2, 0, 0, 0);
        at_neg(); step_edge();
        drive(1, 1, BLT_OP, 0, 2, 2, 0);
        at_neg();
        chk("pre-reset stall", bus1.stall, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("rst L1 stall", bus1.stall, 0);
        chk("rst L1 haz", {bus1.haz_rs, bus1.haz_rd}, 0);
        chk("rst L1 fwd", {bus1.fwd_rs_sel, bus1.fwd_rd_sel}, 0);
        chk("rst L1 count", bus1.stall_count, 0);
        chk("rst L2 stall", bus2.stall, 0);
        chk("rst L2 count", bus2.stall_count, 0);
        hq0.delete(); hq1.delete(); cnt0 = 0; cnt1 = 0;
        @(posedge clock);
        #1 reset_n = 1'b1;

        foreach (vq[i]) begin
            drive(vq[i].v, vq[i].br, vq[i].opc, vq[i].wr, vq[i].rs, vq[i].rd, vq[i].fl);
            at_neg();
            chk($sformatf("vec%0d stall", i), bus1.stall, vq[i].st);
            chk($sformatf("vec%0d fwd_rs", i), bus1.fwd_rs_sel, vq[i].fs);
            chk($sformatf("vec%0d fwd_rd", i), bus1.fwd_rd_sel, vq[i].fd);
            chk($sformatf("vec%0d haz_rs", i), bus1.haz_rs, vq[i].hs);
            chk($sformatf("vec%0d haz_rd", i), bus1.haz_rd, vq[i].hd);
            chk($sformatf("vec%0d count", i), bus1.stall_count, vq[i].cnt);
            step_edge();
        end

        // Load-use stall length versus LOAD_LAT: 1 and 2 stall cycles.
        drive(0, 0, ALU_OP, 0, 0, 0, 0);
        repeat (3) begin at_neg(); step_edge(); end
        drive(1, 0, LW_OP, 7, 0, 0, 0);
        at_neg(); step_edge();
        drive(1, 1, BLT_OP, 0, 1, 7, 0);
        n1 = 0; n2 = 0; fd1 = -1; fd2 = -1; d1 = 0; d2 = 0;
        for (int i = 0; i < 6 && !(d1 && d2); i++) begin
            at_neg();
            if (!d1) begin
                if (bus1.stall) n1++; else begin d1 = 1; fd1 = int'(bus1.fwd_rd_sel); end
            end
            if (!d2) begin
                if (bus2.stall) n2++; else begin d2 = 1; fd2 = int'(bus2.fwd_rd_sel); end
            end
            step_edge();
        end
        chk("lat1 stall cycles", n1, 1);
        chk("lat1 fwd after", fd1, 2);
        chk("lat2 stall cycles", n2, 2);
        chk("lat2 fwd after", fd2, 3);

        // 300 load-use pairs; counter must pin at 255.
        for (int p = 0; p < 300; p++) begin
            drive(1, 0, LW_OP, 1, 0, 0, 0);
            at_neg(); step_edge();
            drive(1, 1, BLT_OP, 0, 1, 1, 0);
            ok = 0;
            for (int c = 0; c < 5 && ok == 0; c++) begin
                at_neg();
                if (!bus1.stall && !bus2.stall) ok = 1;
                step_edge();
            end
            if (ok == 0) begin
                chk("stall release timeout", 0, 1);
                break;
            end
        end
        drive(0, 0, ALU_OP, 0, 0, 0, 0);
        at_neg();
        chk("sat L1 count", bus1.stall_count, 255);
        chk("sat L2 count", bus2.stall_count, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_hazard_unit.md
# branch_hazard_unit

Parametrised branch-operand hazard controller for the pipelined CPU, sitting beside the decode stage and driving the stall and bypass muxes feeding the blt/bne comparator. It keeps a shadow scoreboard of in-flight register writers (ALU, addi, lw) from execute through writeback. Each cycle it decides, for a branch in decode, whether each compare operand must be bypassed (and from which stage) or whether decode must stall on a load still in flight. It also counts stall cycles for the performance display.

## Interface
- REG_W, 5, register-index width
- OP_W, 5, opcode width
- DEPTH, 3, in-flight stages tracked (1 = X, 2 = M, 3 = W)
- LOAD_LAT, 1, a load at stage k ≤ LOAD_LAT cannot be bypassed; range 1..DEPTH-1
- ALU_OP, 5'b00000, R-type ALU opcode
- ADDI_OP, 5'b00101, addi opcode
- LW_OP, 5'b01000, load-word opcode
- SEL_W, $clog2(DEPTH+1), bypass-select width
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_is_branch  in  1  decode instruction is blt or bne
- id_opcode  in  OP_W  decode opcode
- id_wr_reg  in  REG_W  decode destination register
- id_rs, id_rd  in  REG_W  branch compare operands
- flush  in  1  squash decode this cycle (taken branch / jump)
- stall  out  1  hold fetch/decode, inject bubble into X
- fwd_rs_sel, fwd_rd_sel  out  SEL_W  0 = register file, k = bypass from stage k
- haz_rs, haz_rd  out  1  operand matches some in-flight writer
- stall_count  out  8  saturating count of stall cycles

## Operation
- Scoreboard entries e[1..DEPTH], each {v, dst, ld}, all registered. The decode instruction is a writer when id_valid=1, id_opcode ∈ {ALU_OP, ADDI_OP, LW_OP} and id_wr_reg ≠ 0. ld=1 only for LW_OP.
- Every cycle e[k+1] ← e[k]. e[DEPTH] falls off the end.
- e[1] ← the decode writer when stall=0 and flush=0. Otherwise e[1] ← bubble (v=0).
- Match for operand x (rs or rd): select the smallest k with e[k].v=1 and e[k].dst=x. Register 0 never matches. haz_x=1 on any match. The youngest writer wins.
- Operands are evaluated only when id_valid & id_is_branch. Otherwise haz_* = 0, fwd_* = 0 and stall = 0.
- Load blocking: the matched entry has ld=1 and k ≤ LOAD_LAT. In that case stall=1, and fwd for that operand = 0.
- Otherwise fwd_x_sel = k on a match, and 0 when there is no match.
- stall = (rs blocked | rd blocked) & ~flush.
- flush=1 forces stall=0, and e[1] takes a bubble.
- stall_count increments on every clock with stall=1 and holds at 255.

## Timing
- stall, fwd_*_sel and haz_* are combinational from the registered scoreboard and the current decode inputs, with zero-cycle latency.
- Scoreboard and stall_count update on the rising clock edge.
- A load followed immediately by a dependent branch stalls exactly LOAD_LAT cycles. The branch then sees fwd = LOAD_LAT+1.
- Reset (asynchronous, any time, including mid-stall):
  - all e[k].v = 0 and stall_count = 0
  - all outputs are therefore 0
  - the in-progress stall is abandoned

## Structure
- Shared package `cpu_pkg`: opcode constants ALU_OP / ADDI_OP / LW_OP / BNE_OP / BLT_OP, REG_W, OP_W, and the scoreboard-entry struct {v, dst, ld}.
- One natural sub-module, `hazard_match`: one operand against DEPTH entries, producing the youngest-match index and its ld bit. It is instantiated twice, for rs and rd.

## Test plan
- Reset: assert reset_n=0 mid-stream. All outputs are 0 and stall_count = 0. First cycle after release: a branch on r3 gives fwd_rs_sel = 0.
- addi r5 issues, then bne r5,r6 next cycle. Required: fwd_rs_sel = 1, haz_rs = 1, stall = 0. One bubble later the same branch gives fwd_rs_sel = 2.
- lw r7, then blt r1,r7. Required: stall = 1 for exactly 1 cycle, stall_count = 1, then fwd_rd_sel = 2.
- Repeat with LOAD_LAT = 2. Required: 2 stall cycles, then fwd = 3.
- add r4 then addi r4 back-to-back, then bne r4,r4. Required: both sel = 1 (youngest wins).
- Branch operand r0 after a writer to r0 (id_wr_reg = 0 is not recorded). Required: haz = 0, fwd = 0.
- lw r2 then blt r2,r2, with flush = 1 in the stall cycle. Required: stall = 0, a bubble enters X, and the counter is unchanged.
- Force 300 stall cycles. Required: stall_count saturates at 255.
